matrix_csr_access_ctrl: RTL and testbench

Initiator side of the matrix CSR file: accepts decoded matrix CSR instructions (CSRRW/S/C and immediate forms) from the matrix dispatch stage and performs the read-modify-write sequence against the CSR register block over a valid/ready request/response channel. It returns the old CSR value for rd, or an illegal-instruction flag. One instruction is in flight at a time.

---
 rtl/matrix_csr_access_ctrl_pkg.sv | 53 +++++
 rtl/matrix_csr_access_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_matrix_csr_access_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_csr_access_ctrl_pkg.sv
// Shared definitions for the matrix CSR access controller: CSR addresses,
// the CSR operation and FSM state encodings, the address decoder and the
// read-modify-write data function.
package matrix_csr_pkg;

  // Widest CSR data path the write-data helper supports.
  localparam int CSR_MAX_W = 64;

  localparam logic [11:0] XMRSTART = 12'h802;
  localparam logic [11:0] XMCSR    = 12'h803;
  localparam logic [11:0] XMSIZE   = 12'h804;
  localparam logic [11:0] XMLENB   = 12'hCC0;
  localparam logic [11:0] XRLENB   = 12'hCC1;
  localparam logic [11:0] XMISA    = 12'hCC2;

  typedef enum logic [1:0] {
    CSR_OP_ILL = 2'b00,
    CSR_OP_RW  = 2'b01,
    CSR_OP_RS  = 2'b10,
    CSR_OP_RC  = 2'b11
  } csr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RESULT
  } state_e;

  // True for the six CSRs that live in the matrix CSR block.
  function automatic logic is_matrix_csr(input logic [11:0] addr);
    return (addr == XMRSTART) || (addr == XMCSR)  || (addr == XMSIZE) ||
           (addr == XMLENB)   || (addr == XRLENB) || (addr == XMISA);
  endfunction

  // New CSR value for the write phase; narrower data paths zero-extend in
  // and truncate out.
  function automatic logic [CSR_MAX_W-1:0] csr_wdata(input csr_op_e op,
                                                     input logic [CSR_MAX_W-1:0] old_val,
                                                     input logic [CSR_MAX_W-1:0] operand);
    logic [CSR_MAX_W-1:0] res;
    case (op)
      CSR_OP_RS: res = old_val | operand;
      CSR_OP_RC: res = old_val & ~operand;
      default:   res = operand;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/matrix_csr_access_ctrl.sv
// Matrix CSR access controller: runs the read-modify-write sequence of one
// decoded CSR instruction against the CSR block and returns the old value
// or an illegal-instruction flag.
// Optional feature: define MATRIX_CSR_ACCESS_TIMEOUT_EN to bound each
// response wait to TIMEOUT_CYCLES cycles (expiry reports illegal).
module matrix_csr_access_ctrl
  import matrix_csr_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ID_W           = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [1:0]      issue_op_i,
  input  logic            issue_imm_i,
  input  logic [11:0]     issue_addr_i,
  input  logic [4:0]      issue_rs1_idx_i,
  input  logic [XLEN-1:0] issue_rs1_data_i,
  input  logic [4:0]      issue_rd_i,
  input  logic [ID_W-1:0] issue_id_i,
  output logic            csr_req_valid_o,
  input  logic            csr_req_ready_i,
  output logic            csr_req_we_o,
  output logic [11:0]     csr_req_addr_o,
  output logic [XLEN-1:0] csr_req_wdata_o,
  input  logic            csr_rsp_valid_i,
  input  logic [XLEN-1:0] csr_rsp_rdata_i,
  input  logic            csr_rsp_err_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [4:0]      res_rd_o,
  output logic [XLEN-1:0] res_data_o,
  output logic [ID_W-1:0] res_id_o,
  output logic            res_illegal_o
);

  state_e            state_q, state_d;
  csr_op_e           op_q;
  logic [11:0]       addr_q;
  logic [4:0]        idx_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   operand_q;
  logic [XLEN-1:0]   old_q;
  logic [ID_W-1:0]   id_q;
  logic              illegal_q;
  logic              do_read_q;
  logic              do_write_q;

  logic              dec_do_write;
  logic              dec_do_read;
  logic              dec_illegal;
  logic              timeout_hit;
  logic [CSR_MAX_W-1:0] wdata_full;

  // Decode of the captured instruction; registered while in DECODE.
  always_comb begin
    dec_do_write = (op_q == CSR_OP_RW) || (idx_q != 5'd0);
    dec_do_read  = !((op_q == CSR_OP_RW) && (rd_q == 5'd0));
    dec_illegal  = !is_matrix_csr(addr_q) || (op_q == CSR_OP_ILL) ||
                   (dec_do_write && (addr_q[11:10] == 2'b11));
  end

  assign wdata_full = csr_wdata(op_q, CSR_MAX_W'(old_q), CSR_MAX_W'(operand_q));

`ifdef MATRIX_CSR_ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  // Wait-cycle counter: cleared on the request handshake that enters a
  // WAIT state, then counts every cycle spent waiting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (((state_q == ST_RD_REQ) || (state_q == ST_WR_REQ)) && csr_req_ready_i) begin
      cnt_q <= '0;
    end else if ((state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign timeout_hit = ((state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT)) &&
                       !csr_rsp_valid_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic and all handshake/data outputs.
  always_comb begin
    state_d         = state_q;
    issue_ready_o   = 1'b0;
    csr_req_valid_o = 1'b0;
    csr_req_we_o    = 1'b0;
    csr_req_addr_o  = '0;
    csr_req_wdata_o = '0;
    res_valid_o     = 1'b0;
    res_rd_o        = '0;
    res_data_o      = '0;
    res_id_o        = '0;
    res_illegal_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        issue_ready_o = 1'b1;
        if (issue_valid_i) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (dec_illegal)      state_d = ST_RESULT;
        else if (dec_do_read) state_d = ST_RD_REQ;
        else                  state_d = ST_WR_REQ;
      end
      ST_RD_REQ: begin
        csr_req_valid_o = 1'b1;
        csr_req_addr_o  = addr_q;
        if (csr_req_ready_i) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (csr_rsp_valid_i) begin
          if (csr_rsp_err_i)   state_d = ST_RESULT;
          else if (do_write_q) state_d = ST_WR_REQ;
          else                 state_d = ST_RESULT;
        end else if (timeout_hit) begin
          state_d = ST_RESULT;
        end
      end
      ST_WR_REQ: begin
        csr_req_valid_o = 1'b1;
        csr_req_we_o    = 1'b1;
        csr_req_addr_o  = addr_q;
        csr_req_wdata_o = wdata_full[XLEN-1:0];
        if (csr_req_ready_i) state_d = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (csr_rsp_valid_i || timeout_hit) state_d = ST_RESULT;
      end
      ST_RESULT: begin
        res_valid_o   = 1'b1;
        res_rd_o      = rd_q;
        res_id_o      = id_q;
        res_illegal_o = illegal_q;
        res_data_o    = illegal_q ? '0 : old_q;
        if (res_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Instruction capture, decode flags, old value and exception tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q       <= CSR_OP_ILL;
      addr_q     <= '0;
      idx_q      <= '0;
      rd_q       <= '0;
      operand_q  <= '0;
      old_q      <= '0;
      id_q       <= '0;
      illegal_q  <= 1'b0;
      do_read_q  <= 1'b0;
      do_write_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue_valid_i) begin
            op_q      <= csr_op_e'(issue_op_i);
            addr_q    <= issue_addr_i;
            idx_q     <= issue_rs1_idx_i;
            rd_q      <= issue_rd_i;
            id_q      <= issue_id_i;
            operand_q <= issue_imm_i ? {{(XLEN-5){1'b0}}, issue_rs1_idx_i} : issue_rs1_data_i;
            old_q     <= '0;
            illegal_q <= 1'b0;
          end
        end
        ST_DECODE: begin
          illegal_q  <= dec_illegal;
          do_read_q  <= dec_do_read;
          do_write_q <= dec_do_write;
        end
        ST_RD_WAIT: begin
          if (csr_rsp_valid_i) begin
            old_q <= csr_rsp_rdata_i;
            if (csr_rsp_err_i) illegal_q <= 1'b1;
          end else if (timeout_hit) begin
            illegal_q <= 1'b1;
          end
        end
        ST_WR_WAIT: begin
          if ((csr_rsp_valid_i && csr_rsp_err_i) || timeout_hit) illegal_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_csr_access_ctrl.sv
// Self-checking bench for matrix_csr_access_ctrl: a behavioural CSR-file
// model plans each instruction's expected CSR requests and result, a
// negedge monitor compares the DUT against it every cycle, and directed
// cases pin literal values and latencies before a randomized run.
module tb_matrix_csr_access_ctrl;

  localparam int XLEN = 32;
  localparam int ID_W = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            issue_valid_i;
  logic            issue_ready_o;
  logic [1:0]      issue_op_i;
  logic            issue_imm_i;
  logic [11:0]     issue_addr_i;
  logic [4:0]      issue_rs1_idx_i;
  logic [XLEN-1:0] issue_rs1_data_i;
  logic [4:0]      issue_rd_i;
  logic [ID_W-1:0] issue_id_i;
  logic            csr_req_valid_o;
  logic            csr_req_ready_i;
  logic            csr_req_we_o;
  logic [11:0]     csr_req_addr_o;
  logic [XLEN-1:0] csr_req_wdata_o;
  logic            csr_rsp_valid_i;
  logic [XLEN-1:0] csr_rsp_rdata_i;
  logic            csr_rsp_err_i;
  logic            res_valid_o;
  logic            res_ready_i;
  logic [4:0]      res_rd_o;
  logic [XLEN-1:0] res_data_o;
  logic [ID_W-1:0] res_id_o;
  logic            res_illegal_o;

  always #5 clk_i = ~clk_i;

  matrix_csr_access_ctrl #(.XLEN(XLEN), .ID_W(ID_W), .TIMEOUT_CYCLES(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_op_i(issue_op_i), .issue_imm_i(issue_imm_i), .issue_addr_i(issue_addr_i),
    .issue_rs1_idx_i(issue_rs1_idx_i), .issue_rs1_data_i(issue_rs1_data_i),
    .issue_rd_i(issue_rd_i), .issue_id_i(issue_id_i),
    .csr_req_valid_o(csr_req_valid_o), .csr_req_ready_i(csr_req_ready_i),
    .csr_req_we_o(csr_req_we_o), .csr_req_addr_o(csr_req_addr_o),
    .csr_req_wdata_o(csr_req_wdata_o),
    .csr_rsp_valid_i(csr_rsp_valid_i), .csr_rsp_rdata_i(csr_rsp_rdata_i),
    .csr_rsp_err_i(csr_rsp_err_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_rd_o(res_rd_o),
    .res_data_o(res_data_o), .res_id_o(res_id_o), .res_illegal_o(res_illegal_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Behavioural CSR file (slot order: 802, 803, 804, CC0, CC1, CC2).
  logic [31:0] csr_mem [6];

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
  } req_t;
  req_t exp_q[$];

  logic        exp_res_active = 1'b0;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;
  logic [3:0]  exp_id;
  logic        exp_ill;

  // Monitor -> driver bookkeeping.
  bit          req_hs = 0, res_hs = 0, issue_hs = 0, busy = 0, res_seen = 0;
  bit          last_hs_we = 0;
  int          n_reads = 0, n_writes = 0, issue_cyc = 0, res_cyc = 0;
  logic [31:0] got_data;
  logic        got_ill;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int csr_slot(input logic [11:0] a);
    case (a)
      12'h802: return 0;
      12'h803: return 1;
      12'h804: return 2;
      12'hCC0: return 3;
      12'hCC1: return 4;
      12'hCC2: return 5;
      default: return -1;
    endcase
  endfunction

  // Compare process: every cycle, against the planned expectations.
  initial forever begin
    @(negedge clk_i);
    if (rst_ni) begin
      if (busy) check("issue_ready_busy", issue_ready_o, 0);
      else      check("issue_ready_idle", issue_ready_o, 1);
      if (issue_valid_i && issue_ready_o) begin
        issue_hs  = 1;
        busy      = 1;
        issue_cyc = cyc;
      end
      if (csr_req_valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_req", csr_req_valid_o, 0);
        end else begin
          check("req_we", csr_req_we_o, exp_q[0].we);
          check("req_addr", csr_req_addr_o, exp_q[0].addr);
          if (exp_q[0].we) check("req_wdata", csr_req_wdata_o, exp_q[0].wdata);
          if (csr_req_ready_i) begin
            last_hs_we = csr_req_we_o;
            if (csr_req_we_o) n_writes++;
            else              n_reads++;
            void'(exp_q.pop_front());
            req_hs = 1;
          end
        end
      end
      if (res_valid_o) begin
        if (!exp_res_active) begin
          check("unexpected_res", res_valid_o, 0);
        end else begin
          if (!res_seen) begin
            res_seen = 1;
            res_cyc  = cyc;
            check("reqs_outstanding", exp_q.size(), 0);
          end
          check("res_rd", res_rd_o, exp_rd);
          check("res_data", res_data_o, exp_data);
          check("res_id", res_id_o, exp_id);
          check("res_illegal", res_illegal_o, exp_ill);
          got_data = res_data_o;
          got_ill  = res_illegal_o;
          if (res_ready_i) begin
            res_hs         = 1;
            busy           = 0;
            exp_res_active = 1'b0;
          end
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_issue_ready", issue_ready_o, 1);
    check("rst_req_valid", csr_req_valid_o, 0);
    check("rst_req_we", csr_req_we_o, 0);
    check("rst_req_addr", csr_req_addr_o, 0);
    check("rst_req_wdata", csr_req_wdata_o, 0);
    check("rst_res_valid", res_valid_o, 0);
    check("rst_res_rd", res_rd_o, 0);
    check("rst_res_data", res_data_o, 0);
    check("rst_res_id", res_id_o, 0);
    check("rst_res_illegal", res_illegal_o, 0);
  endtask

  task automatic idle_inputs();
    issue_valid_i   = 0;
    csr_req_ready_i = 0;
    csr_rsp_valid_i = 0;
    csr_rsp_err_i   = 0;
    csr_rsp_rdata_i = '0;
    res_ready_i     = 0;
  endtask

  // Plan one instruction in the model, drive it, act as CSR block and
  // result consumer. abort_at>0 applies reset at that cycle instead.
  task automatic run_instr(input logic [1:0] op, input logic imm, input logic [11:0] addr,
                           input logic [4:0] idx, input logic [31:0] data, input logic [4:0] rd,
                           input logic [3:0] id, input bit err_rd, input bit err_wr,
                           input int ready_hold, input int ready_pct, input int rsp_max,
                           input int res_pct, input bit stray, input bit no_rsp,
                           input int abort_at, output int lat);
    logic [31:0] operand, old_val, wd;
    bit do_write, do_read, illegal, wr_ok, done;
    int slot, cd, bound;
    req_t r;
    operand  = imm ? {27'b0, idx} : data;
    slot     = csr_slot(addr);
    do_write = (op == 2'b01) || (idx != 0);
    do_read  = !((op == 2'b01) && (rd == 0));
    illegal  = (slot < 0) || (op == 2'b00) || (do_write && addr[11:10] == 2'b11);
    old_val  = (do_read && slot >= 0) ? csr_mem[slot] : 32'h0;
    case (op)
      2'b10:   wd = old_val | operand;
      2'b11:   wd = old_val & ~operand;
      default: wd = operand;
    endcase
    wr_ok = 0;
    exp_q.delete();
    if (!illegal) begin
      if (do_read) begin
        r.we = 0; r.addr = addr; r.wdata = '0;
        exp_q.push_back(r);
        if (err_rd || no_rsp) illegal = 1;
      end
      if (do_write && !illegal) begin
        r.we = 1; r.addr = addr; r.wdata = wd;
        exp_q.push_back(r);
        if (err_wr || no_rsp) illegal = 1;
        else wr_ok = 1;
      end
    end
    exp_rd   = rd;
    exp_id   = id;
    exp_ill  = illegal;
    exp_data = illegal ? 32'h0 : old_val;
    exp_res_active = 1'b1;
    res_seen = 0; n_reads = 0; n_writes = 0;
    req_hs = 0; res_hs = 0; issue_hs = 0;

    issue_valid_i = 1; issue_op_i = op; issue_imm_i = imm; issue_addr_i = addr;
    issue_rs1_idx_i = idx; issue_rs1_data_i = data; issue_rd_i = rd; issue_id_i = id;
    for (int k = 0; k < 20 && !issue_hs; k++) begin
      @(posedge clk_i); #1;
    end
    check("issue_accepted", issue_hs, 1);
    issue_valid_i = 0;
    issue_op_i = 2'($urandom); issue_imm_i = 1'($urandom); issue_addr_i = 12'($urandom);
    issue_rs1_idx_i = 5'($urandom); issue_rs1_data_i = $urandom; issue_rd_i = 5'($urandom);
    issue_id_i = 4'($urandom);

    cd = 0; done = 0;
    bound = 200 + ready_hold + 40 * rsp_max;
    for (int k = 0; k < bound && !done; k++) begin
      if (abort_at > 0 && k == abort_at) begin
        rst_ni = 0;
        exp_q.delete();
        exp_res_active = 1'b0;
        busy = 0;
        wr_ok = 0;
        done = 1;
        #1;
        check_reset_outputs();
      end else if (res_hs) begin
        done = 1;
      end else begin
        if (req_hs) begin
          req_hs = 0;
          cd = $urandom_range(1, rsp_max);
        end
        csr_rsp_valid_i = 0;
        csr_rsp_err_i   = 1'($urandom);
        csr_rsp_rdata_i = $urandom;
        if (cd > 0) begin
          cd--;
          if (cd == 0 && !no_rsp) begin
            csr_rsp_valid_i = 1;
            csr_rsp_err_i   = last_hs_we ? err_wr : err_rd;
            csr_rsp_rdata_i = last_hs_we ? $urandom : old_val;
          end
        end else if (stray && !no_rsp && $urandom_range(0, 3) == 0) begin
          csr_rsp_valid_i = 1;
        end
        csr_req_ready_i = (k < ready_hold) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
        res_ready_i     = ($urandom_range(0, 99) < res_pct);
        @(posedge clk_i); #1;
      end
    end
    check("result_done", done, 1);
    idle_inputs();
    if (wr_ok) csr_mem[slot] = wd;
    lat = res_cyc - issue_cyc;
    res_hs = 0;
    $display("instr id=%0d op=%0d addr=0x%03h rd=%0d -> ill=%0d data=0x%08h reads=%0d writes=%0d lat=%0d",
             id, op, addr, rd, got_ill, got_data, n_reads, n_writes, lat);
  endtask

  initial begin
    int lat;
    logic [11:0] addrs [6];
    addrs[0] = 12'h802; addrs[1] = 12'h803; addrs[2] = 12'h804;
    addrs[3] = 12'hCC0; addrs[4] = 12'hCC1; addrs[5] = 12'hCC2;
    for (int i = 0; i < 6; i++) csr_mem[i] = $urandom;
    rst_ni = 0;
    idle_inputs();
    issue_op_i = 0; issue_imm_i = 0; issue_addr_i = 0; issue_rs1_idx_i = 0;
    issue_rs1_data_i = 0; issue_rd_i = 0; issue_id_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs();
    rst_ni = 1;
    @(posedge clk_i); #1;

    // RS on XMCSR holding 0xA with rs1=0x5: read 0xA, write 0xF, 6 cycles.
    csr_mem[1] = 32'hA;
    run_instr(2'b10, 0, 12'h803, 5'd3, 32'h5, 5'd7, 4'd1, 0, 0, 0, 100, 1, 100, 0, 0, 0, lat);
    check("rs_data", got_data, 32'hA);
    check("rs_illegal", got_ill, 0);
    check("rs_latency", lat, 6);
    check("rs_new_value", csr_mem[1], 32'hF);
    check("rs_writes", n_writes, 1);

    // RW to read-only XMISA: illegal, no CSR traffic.
    run_instr(2'b01, 0, 12'hCC2, 5'd1, 32'h1234, 5'd4, 4'd2, 0, 0, 0, 100, 1, 100, 1, 0, 0, lat);
    check("ro_illegal", got_ill, 1);
    check("ro_data", got_data, 0);
    check("ro_reqs", n_reads + n_writes, 0);

    // RC immediate with uimm=0 on XMLENB: read only, 4 cycles.
    csr_mem[3] = 32'h1234_5678;
    run_instr(2'b11, 1, 12'hCC0, 5'd0, 32'hFFFF_FFFF, 5'd9, 4'd3, 0, 0, 0, 100, 1, 100, 0, 0, 0, lat);
    check("rc0_data", got_data, 32'h1234_5678);
    check("rc0_illegal", got_ill, 0);
    check("rc0_writes", n_writes, 0);
    check("rc0_latency", lat, 4);

    // RW with rd=0 on XMRSTART: write only, result data 0.
    run_instr(2'b01, 0, 12'h802, 5'd2, 32'h7, 5'd0, 4'd4, 0, 0, 0, 100, 1, 100, 0, 0, 0, lat);
    check("rw0_data", got_data, 0);
    check("rw0_reads", n_reads, 0);
    check("rw0_new_value", csr_mem[0], 32'h7);
    check("rw0_latency", lat, 4);

    // Read request stalled by req_ready low for 10 RD_REQ cycles.
    csr_mem[2] = 32'hF0F0;
    run_instr(2'b11, 0, 12'h804, 5'd5, 32'h00F0, 5'd6, 4'd5, 0, 0, 11, 100, 1, 100, 0, 0, 0, lat);
    check("stall_reads", n_reads, 1);
    check("stall_new_value", csr_mem[2], 32'hF000);
    check("stall_data", got_data, 32'hF0F0);

    // Error response in WR_WAIT: illegal, data 0, value unchanged.
    run_instr(2'b01, 0, 12'h804, 5'd8, 32'h55, 5'd3, 4'd6, 0, 1, 0, 100, 1, 100, 0, 0, 0, lat);
    check("wrerr_illegal", got_ill, 1);
    check("wrerr_data", got_data, 0);
    check("wrerr_value", csr_mem[2], 32'hF000);

`ifdef MATRIX_CSR_ACCESS_TIMEOUT_EN
    // No response at all: timeout after 64 waiting cycles.
    run_instr(2'b10, 0, 12'h803, 5'd0, 32'h0, 5'd2, 4'd7, 0, 0, 0, 100, 1, 100, 0, 1, 0, lat);
    check("tmo_illegal", got_ill, 1);
    check("tmo_data", got_data, 0);
    check("tmo_latency", lat, 67);
`endif

    // Reset while waiting for a read response: instruction dropped.
    run_instr(2'b10, 0, 12'h803, 5'd1, 32'h1, 5'd2, 4'd8, 0, 0, 0, 100, 1, 100, 0, 1, 8, lat);
    check("abort_reads", n_reads, 1);
    repeat (2) @(posedge clk_i);
    #1;
    check("abort_res_valid", res_valid_o, 0);
    rst_ni = 1;
    @(posedge clk_i); #1;

    // Randomized instructions against the model.
    for (int n = 0; n < 250; n++) begin
      logic [11:0] a;
      a = ($urandom_range(0, 9) < 8) ? addrs[$urandom_range(0, 5)] : 12'($urandom);
      run_instr(2'($urandom), 1'($urandom), a,
                ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom,
                ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), 4'($urandom),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                $urandom_range(0, 3), $urandom_range(30, 100), $urandom_range(1, 4),
                $urandom_range(40, 100), 1, 0, 0, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
